// File: rtl/cpu_mul_pkg.sv
// -----------------------------------------------------------------------------
// cpu_mul_pkg
// Shared definitions for the multiplier result-combine slice.
//   MUL_TAG_W : default width of the destination-register tag
//   HALF_W    : width of one operand half (16)
//   mul_pp_t  : the three registered 16x16 partial products
//   cross_sum : low half of p2 + p3 (the carry is not needed for a 32-bit result)
// -----------------------------------------------------------------------------
package cpu_mul_pkg;

    localparam int MUL_TAG_W = 5;
    localparam int HALF_W    = 16;

    typedef struct packed {
        logic [31:0] p1;   // lo(src1) * lo(src2)
        logic [31:0] p2;   // lo(src1) * hi(src2)
        logic [31:0] p3;   // hi(src1) * lo(src2)
    } mul_pp_t;

    // Only bits [15:0] of the cross terms land inside the low 32 bits of the
    // product once shifted left by HALF_W, so the sum is taken modulo 2^16.
    function automatic logic [HALF_W-1:0] cross_sum(input mul_pp_t pp);
        return pp.p2[HALF_W-1:0] + pp.p3[HALF_W-1:0];
    endfunction

endpackage

// File: rtl/cpu_mul_pipe_stage.sv
// -----------------------------------------------------------------------------
// cpu_mul_pipe_stage
// Generic one-entry valid/ready register slice with flush.
//   clk, reset      : clock, synchronous active-high reset (clears valid and data)
//   flush           : drops the held entry on the next edge, blocks input
//   in_valid/ready  : upstream handshake; in_ready is independent of in_valid
//   in_data         : W-bit payload captured on accept
//   out_valid/ready : downstream handshake
//   out_data        : registered payload, stable while stalled
// -----------------------------------------------------------------------------
module cpu_mul_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         w_accept;

    // The slot is free when empty or when its content leaves this cycle,
    // which gives full throughput without a skid buffer.
    assign in_ready = !flush && !reset && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (flush) begin
            // Payload is left stale; only the valid bit matters.
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= in_data;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;

endmodule

// File: rtl/cpu_mul_result_combine.sv
// -----------------------------------------------------------------------------
// cpu_mul_result_combine
// Combines three 16x16 partial products into the low 32 bits of a 32x32
// product through a two-stage valid/ready pipeline with flush.
//   clk, reset             : clock, synchronous active-high reset
//   in_valid/in_ready      : input handshake
//   in_p1, in_p2, in_p3    : lo*lo, lo(src1)*hi(src2), hi(src1)*lo(src2)
//   in_tag                 : destination register index
//   flush                  : squash all in-flight operations
//   out_valid/out_ready    : output handshake
//   out_result, out_tag    : low 32 bits of src1*src2 and its tag
//   busy                   : some stage holds a valid operation
// -----------------------------------------------------------------------------
module cpu_mul_result_combine
    import cpu_mul_pkg::*;
#(
    parameter int TAG_W = MUL_TAG_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_p1,
    input  logic [31:0]      in_p2,
    input  logic [31:0]      in_p3,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int S1_W = TAG_W + 32 + HALF_W;
    localparam int S2_W = TAG_W + 32;

    mul_pp_t           w_pp;
    logic [HALF_W-1:0] w_cross_in;
    logic [S1_W-1:0]   w_s1_in;
    logic [S1_W-1:0]   w_s1_out;
    logic              w_s1_valid;
    logic              w_s2_ready;

    logic [TAG_W-1:0]  w_s1_tag;
    logic [31:0]       w_s1_p1;
    logic [HALF_W-1:0] w_s1_cross;
    logic [31:0]       w_sum;
    logic [S2_W-1:0]   w_s2_in;
    logic [S2_W-1:0]   w_s2_out;

    assign w_pp       = '{p1: in_p1, p2: in_p2, p3: in_p3};
    assign w_cross_in = cross_sum(w_pp);
    assign w_s1_in    = {in_tag, in_p1, w_cross_in};

    cpu_mul_pipe_stage #(.W(S1_W)) u_s1 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_s1_in),
        .out_valid (w_s1_valid),
        .out_ready (w_s2_ready),
        .out_data  (w_s1_out)
    );

    assign {w_s1_tag, w_s1_p1, w_s1_cross} = w_s1_out;

    // Cross terms carry weight 2^16; anything above bit 31 is discarded.
    assign w_sum   = w_s1_p1 + {w_s1_cross, {HALF_W{1'b0}}};
    assign w_s2_in = {w_s1_tag, w_sum};

    cpu_mul_pipe_stage #(.W(S2_W)) u_s2 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (w_s1_valid),
        .in_ready  (w_s2_ready),
        .in_data   (w_s2_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_s2_out)
    );

    assign {out_tag, out_result} = w_s2_out;
    assign busy = w_s1_valid || out_valid;

endmodule

// File: tb/tb_cpu_mul_result_combine.sv
module tb_cpu_mul_result_combine;

    localparam int TAG_W = 5;

    typedef struct {
        logic [31:0]      a;
        logic [31:0]      b;
        logic [TAG_W-1:0] tag;
    } item_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_p1, in_p2, in_p3;
    logic [TAG_W-1:0] in_tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    cpu_mul_result_combine #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_p1      (in_p1),
        .in_p2      (in_p2),
        .in_p3      (in_p3),
        .in_tag     (in_tag),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_out = 0;

    item_t in_q[$];
    item_t exp_q[$];

    logic             prev_stall = 1'b0;
    logic [31:0]      prev_result;
    logic [TAG_W-1:0] prev_tag;
    logic             last_in_ready;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Drive partial products derived from a 32x32 operand pair.
    task automatic drive_src(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
        in_p1  = a[15:0]  * b[15:0];
        in_p2  = a[15:0]  * b[31:16];
        in_p3  = a[31:16] * b[15:0];
        in_tag = t;
    endtask

    // One clock cycle of queue-driven streaming with scoreboard checks.
    // Called right after a negedge; returns at the next negedge.
    task automatic do_cycle(input logic ordy);
        item_t it;
        item_t e;
        logic [31:0] prod;
        out_ready = ordy;
        if (in_q.size() > 0) begin
            in_valid = 1'b1;
            drive_src(in_q[0].a, in_q[0].b, in_q[0].tag);
        end else begin
            in_valid = 1'b0;
        end
        #1;
        last_in_ready = in_ready;
        if (prev_stall) begin
            chk("stall_result_stable", out_result, prev_result);
            chk("stall_tag_stable", 32'(out_tag), 32'(prev_tag));
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 32'(out_valid), 32'd0);
            end else begin
                e    = exp_q.pop_front();
                prod = e.a * e.b;
                chk("stream_tag", 32'(out_tag), 32'(e.tag));
                chk("stream_result", out_result, prod);
                n_out++;
                $display("out tag=%0d result=%h", out_tag, out_result);
            end
        end
        prev_stall  = out_valid && !out_ready;
        prev_result = out_result;
        prev_tag    = out_tag;
        if (in_valid && in_ready) begin
            it = in_q.pop_front();
            exp_q.push_back(it);
        end
        @(negedge clk);
    endtask

    task automatic drain(input int budget, input bit rand_ready);
        int cyc = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
            do_cycle(rand_ready ? ($urandom_range(0, 9) < 7) : 1'b1);
            cyc++;
        end
        chk("drain_timeout", 32'(cyc < budget), 32'd1);
        in_valid   = 1'b0;
        prev_stall = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_p1 = '0; in_p2 = '0; in_p3 = '0; in_tag = '0;
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // 1. basic product with latency check
        in_valid = 1'b1; in_p1 = 32'h8; in_p2 = 32'hA; in_p3 = 32'hC; in_tag = 5'd3;
        #1 chk("t1_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("t1_n1_out_valid", 32'(out_valid), 32'd0);
        chk("t1_n1_busy", 32'(busy), 32'd1);
        @(negedge clk); #1;
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_result", out_result, 32'h00160008);
        chk("t1_tag", 32'(out_tag), 32'd3);
        $display("t1 tag=%0d result=%h", out_tag, out_result);
        @(negedge clk); #1;
        chk("t1_drained", 32'(busy), 32'd0);
        @(negedge clk);

        // 2. wrap-around: all-ones operands
        in_valid = 1'b1; in_p1 = 32'hFFFE0001; in_p2 = 32'hFFFE0001; in_p3 = 32'hFFFE0001; in_tag = 5'd7;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk); #1;
        chk("t2_out_valid", 32'(out_valid), 32'd1);
        chk("t2_result", out_result, 32'h00000001);
        $display("t2 tag=%0d result=%h", out_tag, out_result);
        @(negedge clk);

        // 3. backpressure: four back-to-back inputs, 3-cycle stall
        n_out = 0;
        for (int i = 1; i <= 4; i++)
            in_q.push_back('{a: 32'h1000_0001 * i, b: 32'h0003_0005 + i, tag: TAG_W'(i)});
        do_cycle(1'b1);
        do_cycle(1'b1);
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b0);
            chk("t3_full_in_ready", 32'(last_in_ready), 32'd0);
        end
        drain(40, 1'b0);
        chk("t3_out_count", 32'(n_out), 32'd4);

        // 4. flush with both stages full and input offered
        in_q.push_back('{a: 32'd11, b: 32'd13, tag: 5'd5});
        in_q.push_back('{a: 32'd17, b: 32'd19, tag: 5'd6});
        do_cycle(1'b1);
        do_cycle(1'b1);
        out_ready = 1'b0; flush = 1'b1; in_valid = 1'b1;
        drive_src(32'd23, 32'd29, 5'd7);
        #1;
        chk("t4_flush_in_ready", 32'(in_ready), 32'd0);
        chk("t4_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("t4_out_valid", 32'(out_valid), 32'd0);
        chk("t4_busy", 32'(busy), 32'd0);
        @(negedge clk); #1;
        chk("t4_no_late_output", 32'(out_valid), 32'd0);
        in_q.delete(); exp_q.delete(); prev_stall = 1'b0;
        @(negedge clk);

        // 5. reset mid-operation with full pipeline
        in_q.push_back('{a: 32'h1234_5678, b: 32'h9ABC_DEF0, tag: 5'd8});
        in_q.push_back('{a: 32'hCAFE_F00D, b: 32'h0BAD_BEEF, tag: 5'd9});
        do_cycle(1'b1);
        do_cycle(1'b0);
        out_ready = 1'b0; reset = 1'b1; in_valid = 1'b1;
        #1 chk("t5_rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        #1;
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_out_result", out_result, 32'd0);
        chk("t5_out_tag", 32'(out_tag), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_in_ready_after", 32'(in_ready), 32'd1);
        in_q.delete(); exp_q.delete(); prev_stall = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);

        // 6. random streaming with ~70% out_ready duty
        n_out = 0;
        for (int i = 0; i < 100; i++)
            in_q.push_back('{a: $urandom, b: $urandom, tag: TAG_W'(i)});
        drain(3000, 1'b1);
        chk("t6_out_count", 32'(n_out), 32'd100);
        @(negedge clk); #1;
        chk("t6_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_mul_result_combine.md
Name: cpu_mul_result_combine

Overview:
Downstream stage of the CPU multiplier cell. It consumes the three registered 16x16 unsigned partial products: p1 = lo*lo, p2 = lo(src1)*hi(src2), p3 = hi(src1)*lo(src2). It combines them into the low 32 bits of the 32x32 product through a 2-stage valid/ready pipeline with flush. The result and destination-register tag go to the writeback/result mux.

Parameters:
TAG_W, 5, width of the destination-register tag carried alongside each product

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  partial products on in_p1/in_p2/in_p3 are valid
in_ready  output  1  block accepts input this cycle
in_p1  input  32  lo(src1)*lo(src2)
in_p2  input  32  lo(src1)*hi(src2)
in_p3  input  32  hi(src1)*lo(src2)
in_tag  input  TAG_W  destination register index
flush  input  1  kill all in-flight operations (pipeline squash)
out_valid  output  1  out_result/out_tag valid
out_ready  input  1  consumer accepts result this cycle
out_result  output  32  low 32 bits of src1*src2
out_tag  output  TAG_W  tag of out_result
busy  output  1  any stage holds a valid operation

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: s1_valid = 0, s2_valid = 0, out_valid = 0, out_result = 0, out_tag = 0, busy = 0. in_ready is 0 during the reset cycle.
- Stage 1 (S1), on accept:
  - cross <= (in_p2[15:0] + in_p3[15:0]) mod 2^16; the carry and in_p2/in_p3[31:16] are discarded.
  - p1 <= in_p1; tag <= in_tag; s1_valid <= 1.
- Stage 2 (S2) is the output register: out_result <= (p1 + {cross, 16'h0}) mod 2^32; out_tag <= S1 tag.
- Advance rules:
  - s2_free = !s2_valid || out_ready
  - s1_adv = s1_valid && s2_free
  - in_ready = !flush && !reset && (!s1_valid || s2_free)
  - accept = in_valid && in_ready
- Handshake:
  - Output transfer occurs when out_valid && out_ready.
  - While out_valid && !out_ready, out_result and out_tag hold stable.
  - in_ready has no combinational dependence on in_valid.
- Latency and throughput: with out_ready high, an input accepted at cycle N gives out_valid at N+2. Sustained throughput is 1 per cycle, with no bubbles.
- Order: strictly in order; no drop or duplication under any backpressure pattern.
- Full condition: both stages valid and out_ready low. in_ready = 0, and holds at 0 until out_ready rises.
- Flush, when asserted in a cycle:
  - s1_valid <= 0 and s2_valid <= 0 next edge, regardless of out_ready; no transfer is counted.
  - Input in the same cycle is not accepted.
  - Datapath registers may keep stale values; only the valid bits matter.
- Simultaneous flush and reset: reset dominates; outcome is identical.
- Reset mid-operation: all in-flight operations are lost and outputs take their reset values on the next edge.
- busy = s1_valid || s2_valid.
- Arithmetic: all unsigned modular arithmetic. The result equals (src1*src2) mod 2^32 for any signed or unsigned interpretation.

Decomposition:
- Shared package cpu_mul_pkg holds:
  - MUL_TAG_W default (5)
  - localparam HALF_W = 16
  - typedef mul_pp_t: struct of p1/p2/p3, 32 bits each
- One natural sub-module: cpu_mul_pipe_stage, a generic valid/ready register slice with flush. It is instantiated twice, with combinational cross-sum and final-add logic between the instances.

Test Plan:
1. Basic product: p1 = 0x00000008, p2 = 0x0000000A, p3 = 0x0000000C, tag = 3 (src1 = 0x00030002, src2 = 0x00050004), out_ready = 1 -> out_valid two cycles after accept, out_result = 0x00160008, out_tag = 3.
2. Wrap-around: src1 = src2 = 0xFFFFFFFF, so p1 = p2 = p3 = 0xFFFE0001 -> out_result = 0x00000001 (cross carry and upper half discarded).
3. Backpressure: 4 back-to-back inputs with tags 1..4, out_ready low for 3 cycles after the first out_valid -> in_ready falls once both stages are full; outputs are tags 1,2,3,4 in order; out_result stays stable while stalled.
4. Flush: flush asserted while S1 and S2 are both valid, with in_valid = 1 in the same cycle -> next cycle out_valid = 0 and busy = 0; the input is not accepted (in_ready = 0); no output for the flushed tags.
5. Reset mid-operation: reset with the pipeline full and out_ready = 0 -> next edge out_valid = 0, out_result = 0, out_tag = 0, busy = 0; in_ready = 1 in the first cycle after reset deasserts.
6. Streaming: 100 random src pairs, random out_ready at 70% duty -> every out_result equals (src1*src2) & 0xFFFFFFFF, in order, with no loss or duplication.
